// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment display path (scanner and BCD decoder).
package seven_seg_pkg;

  localparam logic [3:0] BLANK_CODE         = 4'hF;
  localparam int         DEFAULT_NUM_DIGITS = 4;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV enabled clocks, synchronous clear.
module tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en & ~clr & (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode scan driver with per-frame input snapshot and
// optional leading-zero suppression; feeds the BCD-to-segment decoder.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int         NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int         REFRESH_DIV = 100000,
  parameter logic [3:0] BLANK_CODE  = seven_seg_pkg::BLANK_CODE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [3:0]              digit,
  output logic                    dot,
  output logic                    frame_tick
);

  localparam int IDXW = $clog2(NUM_DIGITS);
  typedef logic [IDXW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_DIGITS - 1);

  logic                    tick;
  idx_t                    idx;
  idx_t                    idx_n;
  logic                    new_frame;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dots;
  logic                    snap_blank_lz;
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dots;
  logic                    src_blank_lz;
  logic [3:0]              nib [NUM_DIGITS];
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   next_an;
  logic [3:0]              next_digit;
  logic                    next_dot;

  tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (~enable),
    .en   (enable),
    .tick (tick)
  );

  // The slot that opens a frame decodes straight from the live inputs, so
  // digit 0 shows the values being captured rather than the stale snapshot.
  always_comb begin
    idx_n        = (idx == LAST_IDX) ? '0 : idx + idx_t'(1);
    new_frame    = (idx_n == '0);
    src_digits   = new_frame ? digits   : snap_digits;
    src_dots     = new_frame ? dots     : snap_dots;
    src_blank_lz = new_frame ? blank_lz : snap_blank_lz;
    upper_zero   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = src_digits[4*i +: 4];
      if ((i >= int'(idx_n)) && (nib[i] != 4'h0)) upper_zero = 1'b0;
    end
    next_digit = (src_blank_lz && (idx_n != '0) && upper_zero) ? BLANK_CODE : nib[idx_n];
    next_dot   = src_dots[idx_n];
    next_an    = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_n);
  end

  // Disabling parks the index on the last digit so the first tick after
  // re-enable always opens a fresh frame at digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= LAST_IDX;
      snap_digits   <= '0;
      snap_dots     <= '0;
      snap_blank_lz <= 1'b0;
      an            <= '1;
      digit         <= BLANK_CODE;
      dot           <= 1'b0;
      frame_tick    <= 1'b0;
    end else if (!enable) begin
      idx        <= LAST_IDX;
      an         <= '1;
      digit      <= BLANK_CODE;
      dot        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick & new_frame;
      if (tick) begin
        idx   <= idx_n;
        an    <= next_an;
        digit <= next_digit;
        dot   <= next_dot;
        if (new_frame) begin
          snap_digits   <= digits;
          snap_dots     <= dots;
          snap_blank_lz <= blank_lz;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4-digit/div-4 instance for the main
// behaviour, 8-digit/div-3 instance for scan-coverage checks.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dots;
  logic        blank_lz;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dot;
  logic        frame_tick;

  logic [31:0] digits8;
  logic [7:0]  dots8;
  logic        blank_lz8;
  logic [7:0]  an8;
  logic [3:0]  digit8;
  logic        dot8;
  logic        frame_tick8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dots;
    logic        blank_lz;
    logic [15:0] exp_digits;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CODE  (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits     (digits),
    .dots       (dots),
    .blank_lz   (blank_lz),
    .an         (an),
    .digit      (digit),
    .dot        (dot),
    .frame_tick (frame_tick)
  );

  seven_seg_scanner #(
    .NUM_DIGITS  (8),
    .REFRESH_DIV (3),
    .BLANK_CODE  (4'hF)
  ) dut8 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits     (digits8),
    .dots       (dots8),
    .blank_lz   (blank_lz8),
    .an         (an8),
    .digit      (digit8),
    .dot        (dot8),
    .frame_tick (frame_tick8)
  );

  task automatic checkOutput(input string tag, input logic [3:0] e_an, input logic [3:0] e_digit,
                             input logic e_dot, input logic e_ft);
    checks++;
    if ({an, digit, dot, frame_tick} !== {e_an, e_digit, e_dot, e_ft}) begin
      errors++;
      $display("[TB] FAIL %s: got an=%b digit=%h dot=%b frame_tick=%b, expected an=%b digit=%h dot=%b frame_tick=%b",
               tag, an, digit, dot, frame_tick, e_an, e_digit, e_dot, e_ft);
    end
  endtask

  // Checks slots first..last, four cycles each; caller is already positioned
  // on the first cycle of slot 'first'.
  task automatic checkSlots(input string tag, input logic [15:0] exp_digits,
                            input logic [3:0] exp_dots, input int first, input int last);
    logic [3:0] e_an;
    for (int s = first; s <= last; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(s == first && c == 0)) @(negedge clk);
        e_an = ~(4'b0001 << s);
        checkOutput($sformatf("%s slot%0d cyc%0d", tag, s, c), e_an, exp_digits[4*s +: 4],
                    exp_dots[s], (s == 0 && c == 0));
      end
    end
  endtask

  task automatic waitFrame(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: frame_tick=0 for 64 cycles, expected a pulse", tag);
    end
  endtask

  // Leaves the caller on the first cycle of the first lit slot.
  task automatic applyStimulus(input string tag);
    rst = 1'b1;
    #1;
    checkOutput({tag, " in reset"}, 4'b1111, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput({tag, " dark0"}, 4'b1111, 4'hF, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s dark%0d", tag, k), 4'b1111, 4'hF, 1'b0, 1'b0);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int low [8];
    int bad;
    int fts;
    int lit;
    bit found;

    vecs[0] = '{16'h1234, 4'b0010, 1'b0, 16'h1234};
    vecs[1] = '{16'h0040, 4'b0000, 1'b1, 16'hFF40};
    vecs[2] = '{16'h0000, 4'b1000, 1'b1, 16'hFFF0};
    vecs[3] = '{16'h00A0, 4'b0101, 1'b1, 16'hFFA0};
    vecs[4] = '{16'h1004, 4'b0000, 1'b1, 16'h1004};
    vecs[5] = '{16'h0040, 4'b0110, 1'b0, 16'h0040};

    rst       = 1'b1;
    enable    = 1'b1;
    digits    = 16'h1234;
    dots      = 4'b0010;
    blank_lz  = 1'b0;
    digits8   = 32'h87654321;
    dots8     = 8'hA5;
    blank_lz8 = 1'b0;
    @(negedge clk);

    // Power-on startup and two full frames
    applyStimulus("t1");
    checkSlots("t1 frame", 16'h1234, 4'b0010, 0, 3);
    @(negedge clk);
    checkSlots("t1 repeat", 16'h1234, 4'b0010, 0, 3);

    for (int v = 0; v < 6; v++) begin
      digits   = vecs[v].digits;
      dots     = vecs[v].dots;
      blank_lz = vecs[v].blank_lz;
      waitFrame($sformatf("vec%0d", v));
      checkSlots($sformatf("vec%0d", v), vecs[v].exp_digits, vecs[v].dots, 0, 3);
    end

    // Mid-frame input change must not tear the current frame
    digits   = 16'h1234;
    dots     = 4'b0000;
    blank_lz = 1'b0;
    waitFrame("t3");
    checkSlots("t3 first", 16'h1234, 4'b0000, 0, 0);
    @(negedge clk);
    digits = 16'h5678;
    checkSlots("t3 old", 16'h1234, 4'b0000, 1, 3);
    waitFrame("t3 next");
    checkSlots("t3 new", 16'h5678, 4'b0000, 0, 3);

    // Disable mid-slot, then re-enable
    waitFrame("t4");
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("t4 off0", 4'b1111, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4 off1", 4'b1111, 4'hF, 1'b0, 1'b0);
    enable = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t4 wait%0d", k), 4'b1111, 4'hF, 1'b0, 1'b0);
    end
    @(negedge clk);
    checkSlots("t4 reenable", 16'h5678, 4'b0000, 0, 3);

    // Asynchronous reset between edges
    digits = 16'h1234;
    dots   = 4'b0010;
    waitFrame("t5");
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5 async", 4'b1111, 4'hF, 1'b0, 1'b0);
    applyStimulus("t5");
    checkSlots("t5 frame", 16'h1234, 4'b0010, 0, 3);

    // 8-digit instance: two whole frames of scan coverage
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_tick8) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL t6 start: frame_tick8=0 for 64 cycles, expected a pulse");
    end
    for (int b = 0; b < 8; b++) low[b] = 0;
    bad = 0;
    fts = 0;
    for (int c = 0; c < 48; c++) begin
      if (c > 0) @(negedge clk);
      if (frame_tick8) fts++;
      lit = -1;
      for (int b = 0; b < 8; b++) begin
        if (!an8[b]) begin
          low[b]++;
          lit = b;
        end
      end
      if ($countones(~an8) != 1) bad++;
      else if (digit8 !== digits8[4*lit +: 4] || dot8 !== dots8[lit]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL t6 onehot: %0d bad cycles, expected 0", bad);
    end
    checks++;
    if (fts != 2) begin
      errors++;
      $display("[TB] FAIL t6 frame_tick: %0d pulses in 48 cycles, expected 2", fts);
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (low[b] != 6) begin
        errors++;
        $display("[TB] FAIL t6 an%0d: low %0d cycles in 48, expected 6", b, low[b]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
